// File: rtl/pipeline_stall_controller.sv
// Stall/flush/freeze arbiter for the 5-stage pipeline of the 8-bit core.
// Optional perf counters: define STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hz_pc_write,
    input  logic       hz_ifid_write,
    input  logic       hz_nop_control,
    input  logic       branch_taken,
    input  logic       mem_busy,
    input  logic       halt_req,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_bubble,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       halted,
    output logic       mem_timeout_err,
    output logic [1:0] ctrl_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;
    logic       load_use;

    assign load_use = hz_nop_control | ~hz_pc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        if (!rst_n || state_q == HALTED) begin
            state_d = state_q;
        end else if (halt_req) begin
            state_d = HALTED;
        end else if (mem_busy) begin
            state_d = MEM_WAIT;
            wcnt_d  = wcnt_q + 8'd1;
            if (wcnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = HALTED;
            end
        end else begin
            wcnt_d   = '0;
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken) begin
                // the stalled instruction is wrong-path, so load-use is dropped
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                fcnt_d      = FL_LOAD;
                state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (state_q == FLUSH) begin
                ifid_flush = 1'b1;
                fcnt_d     = fcnt_q - 3'd1;
                if (fcnt_q <= 3'd1) state_d = RUN;
            end else begin
                state_d = (state_q == MEM_WAIT && fcnt_q != 3'd0)
                        ? FLUSH : RUN;
                if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
        end
    end

    assign halted          = rst_n & (state_q == HALTED);
    assign mem_timeout_err = err_q;
    assign ctrl_state      = state_q;

`ifdef STALL_PERF_CNT_EN
    logic lu_hit, frz_hit;

    // a bubble without a flush is a load-use stall, not a branch kill
    assign lu_hit  = idex_bubble & ~ifid_flush;
    assign frz_hit = rst_n & mem_busy & ~halt_req & (state_q != HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_stall_cnt <= '0;
            mem_stall_cnt  <= '0;
            flush_cnt      <= '0;
        end else begin
            if (lu_hit && !(&load_stall_cnt))
                load_stall_cnt <= load_stall_cnt + CNT_W'(1);
            if (frz_hit && !(&mem_stall_cnt))
                mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
            if (ifid_flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances with different
// flush/timeout parameters, expected outputs queued and compared per cycle.
module tb_pipeline_stall_controller;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_FL  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;
    localparam logic [1:0] S_HLT = 2'd3;

    // {pc, ifid, flush, idex, bubble, exmem, memwb}
    localparam logic [6:0] NORM = 7'b1101011;
    localparam logic [6:0] LU   = 7'b0001111;
    localparam logic [6:0] BR   = 7'b1111111;
    localparam logic [6:0] FL   = 7'b1111011;
    localparam logic [6:0] Z    = 7'b0000000;

    // {pc_write, ifid_write, nop, branch, busy, halt}
    localparam logic [5:0] I_IDLE = 6'b110000;
    localparam logic [5:0] I_LU   = 6'b001000;
    localparam logic [5:0] I_BRLU = 6'b001100;
    localparam logic [5:0] I_BR   = 6'b110100;
    localparam logic [5:0] I_BSY  = 6'b110010;
    localparam logic [5:0] I_BSBR = 6'b110110;
    localparam logic [5:0] I_HALT = 6'b110001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] in;
    logic       hz_pc_write, hz_ifid_write, hz_nop_control;
    logic       branch_taken, mem_busy, halt_req;

    assign {hz_pc_write, hz_ifid_write, hz_nop_control,
            branch_taken, mem_busy, halt_req} = in;

    logic       a_pc, a_ifid, a_fl, a_idex, a_bub, a_exm, a_mwb, a_h, a_err;
    logic [1:0] a_st;
    logic       b_pc, b_ifid, b_fl, b_idex, b_bub, b_exm, b_mwb, b_h, b_err;
    logic [1:0] b_st;
    logic [10:0] obs_a, obs_b;

    assign obs_a = {a_pc, a_ifid, a_fl, a_idex, a_bub, a_exm, a_mwb,
                    a_h, a_err, a_st};
    assign obs_b = {b_pc, b_ifid, b_fl, b_idex, b_bub, b_exm, b_mwb,
                    b_h, b_err, b_st};

`ifdef STALL_PERF_CNT_EN
    logic [15:0] a_lsc, a_msc, a_fc;
    logic [1:0]  b_lsc, b_msc, b_fc;
`endif

    pipeline_stall_controller #(
        .FLUSH_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .hz_pc_write(hz_pc_write), .hz_ifid_write(hz_ifid_write),
        .hz_nop_control(hz_nop_control), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_en(a_pc), .ifid_en(a_ifid), .ifid_flush(a_fl),
        .idex_en(a_idex), .idex_bubble(a_bub), .exmem_en(a_exm),
        .memwb_en(a_mwb), .halted(a_h), .mem_timeout_err(a_err),
        .ctrl_state(a_st)
`ifdef STALL_PERF_CNT_EN
        , .load_stall_cnt(a_lsc), .mem_stall_cnt(a_msc), .flush_cnt(a_fc)
`endif
    );

    pipeline_stall_controller #(
        .FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(2)
    ) u_to (
        .clk(clk), .rst_n(rst_n),
        .hz_pc_write(hz_pc_write), .hz_ifid_write(hz_ifid_write),
        .hz_nop_control(hz_nop_control), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_en(b_pc), .ifid_en(b_ifid), .ifid_flush(b_fl),
        .idex_en(b_idex), .idex_bubble(b_bub), .exmem_en(b_exm),
        .memwb_en(b_mwb), .halted(b_h), .mem_timeout_err(b_err),
        .ctrl_state(b_st)
`ifdef STALL_PERF_CNT_EN
        , .load_stall_cnt(b_lsc), .mem_stall_cnt(b_msc), .flush_cnt(b_fc)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        bit          b;
        logic [10:0] exp;
    } sb_t;

    sb_t sbq[$];

    function automatic logic [10:0] e(logic [6:0] en, logic h,
                                      logic er, logic [1:0] st);
        return {en, h, er, st};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(string tag, logic [5:0] v,
                        logic [10:0] ea, logic [10:0] eb);
        sb_t s;
        in    = v;
        s.tag = {tag, "_a"};
        s.b   = 1'b0;
        s.exp = ea;
        sbq.push_back(s);
        s.tag = {tag, "_b"};
        s.b   = 1'b1;
        s.exp = eb;
        sbq.push_back(s);
        @(negedge clk);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            check(s.tag, 32'(s.b ? obs_b : obs_a), 32'(s.exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        in    = I_IDLE;
        @(negedge clk);
        check({tag, "_a"}, 32'(obs_a), 32'd0);
        check({tag, "_b"}, 32'(obs_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in    = I_IDLE;
        @(posedge clk);
        #1;
        do_reset("rst0");

        step("lu", I_LU, e(LU, 0, 0, S_RUN), e(LU, 0, 0, S_RUN));
        step("lu_end", I_IDLE, e(NORM, 0, 0, S_RUN), e(NORM, 0, 0, S_RUN));

        step("brlu", I_BRLU, e(BR, 0, 0, S_RUN), e(BR, 0, 0, S_RUN));
        step("fl1", I_LU, e(FL, 0, 0, S_FL), e(LU, 0, 0, S_RUN));
        step("fl_end", I_IDLE, e(NORM, 0, 0, S_RUN), e(NORM, 0, 0, S_RUN));

        do_reset("rst1");
        for (int i = 0; i < 5; i++)
            step("frz", I_BSBR,
                 e(Z, 0, 0, (i == 0) ? S_RUN : S_MW),
                 (i == 4) ? e(Z, 1, 1, S_HLT)
                          : e(Z, 0, 0, (i == 0) ? S_RUN : S_MW));
        step("frz_exit", I_BR, e(BR, 0, 0, S_MW), e(Z, 1, 1, S_HLT));
        step("frz_fl", I_IDLE, e(FL, 0, 0, S_FL), e(Z, 1, 1, S_HLT));
        step("frz_run", I_IDLE, e(NORM, 0, 0, S_RUN), e(Z, 1, 1, S_HLT));

        do_reset("rst2");
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++)
                step("pulse", I_BSY,
                     e(Z, 0, 0, (i == 0) ? S_RUN : S_MW),
                     e(Z, 0, 0, (i == 0) ? S_RUN : S_MW));
            step("pulse_gap", I_IDLE, e(NORM, 0, 0, S_MW),
                 e(NORM, 0, 0, S_MW));
        end

        do_reset("rst3");
        for (int i = 0; i < 4; i++)
            step("to_busy", I_BSY,
                 e(Z, 0, 0, (i == 0) ? S_RUN : S_MW),
                 e(Z, 0, 0, (i == 0) ? S_RUN : S_MW));
        step("to_drop", I_IDLE, e(NORM, 0, 0, S_MW), e(Z, 1, 1, S_HLT));
        step("to_br", I_BR, e(BR, 0, 0, S_RUN), e(Z, 1, 1, S_HLT));
        step("to_hold", I_IDLE, e(FL, 0, 0, S_FL), e(Z, 1, 1, S_HLT));

        do_reset("rst4");
        step("halt", I_HALT, e(Z, 0, 0, S_RUN), e(Z, 0, 0, S_RUN));
        step("hlt1", I_IDLE, e(Z, 1, 0, S_HLT), e(Z, 1, 0, S_HLT));
        step("hlt2", I_BRLU, e(Z, 1, 0, S_HLT), e(Z, 1, 0, S_HLT));
        do_reset("rst5");
        step("post", I_IDLE, e(NORM, 0, 0, S_RUN), e(NORM, 0, 0, S_RUN));

`ifdef STALL_PERF_CNT_EN
        do_reset("rst6");
        for (int i = 0; i < 5; i++)
            step("cnt_lu", I_LU, e(LU, 0, 0, S_RUN), e(LU, 0, 0, S_RUN));
        check("lsc_a", 32'(a_lsc), 32'd5);
        check("lsc_b_sat", 32'(b_lsc), 32'd3);
        check("fc_b", 32'(b_fc), 32'd0);
        check("msc_b", 32'(b_msc), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the stall requests from the hazard detection unit, plus the branch-taken, memory-busy and halt signals.
- Drives the per-stage write enables, the IF/ID flush and the ID/EX bubble for the 5-stage pipeline of the 8-bit core.
- Arbitrates simultaneous stall, flush and freeze requests by fixed priority.
- Tracks multi-cycle flush and memory-wait windows, including a memory timeout that halts the core.

Parameters:
- FLUSH_CYCLES, 1, IF/ID flush cycles per taken branch (1..7).
- MEM_TIMEOUT, 64, consecutive mem_busy cycles before timeout error (2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hz_pc_write  in  1  hazard unit PC write enable (0 = load-use stall).
- hz_ifid_write  in  1  hazard unit IF/ID write enable.
- hz_nop_control  in  1  hazard unit bubble request.
- branch_taken  in  1  EX-stage taken branch/jump, level, valid while EX holds the instruction.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- halt_req  in  1  ID-stage HALT opcode decoded.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_en  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX loads all-zero control (NOP).
- exmem_en  out  1  EX/MEM write enable.
- memwb_en  out  1  MEM/WB write enable.
- halted  out  1  core halted.
- mem_timeout_err  out  1  sticky timeout flag.
- ctrl_state  out  2  current FSM state (debug).

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2, HALTED=3.
- Enables, flush and bubble are Mealy outputs of the state and the current inputs, with zero-cycle latency. State and counters are registered.
- While rst_n is low:
  - All outputs are 0.
  - State is RUN; flush counter, wait counter, halted and mem_timeout_err are cleared.
  - An active flush or wait window is abandoned.
- Request priority in RUN, FLUSH and MEM_WAIT, highest first:
  - halt_req: all enables 0, no flush or bubble; next state HALTED. halted rises the following cycle.
  - mem_busy: all five enables 0, flush 0, bubble 0; next state MEM_WAIT.
    - The wait counter increments every busy cycle.
    - On the busy cycle where the counter equals MEM_TIMEOUT-1, mem_timeout_err sets and next state is HALTED.
  - branch_taken:
    - Outputs: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, idex_en=exmem_en=memwb_en=1.
    - Any simultaneous load-use request is discarded, because the stalled instruction is wrong-path.
    - If FLUSH_CYCLES>1, next state is FLUSH with the flush counter loaded with FLUSH_CYCLES-1.
  - Load-use stall (hz_nop_control=1 or hz_pc_write=0): pc_en=0, ifid_en=0, idex_bubble=1, later stages enabled.
  - Otherwise: all enables 1, flush 0, bubble 0.
- FLUSH state:
  - ifid_flush=1 every cycle; the flush counter decrements.
  - Return to RUN when the counter reaches 1.
  - A load-use request is ignored while ifid_flush=1.
  - A new branch_taken reloads the counter.
  - mem_busy preempts the flush; the remaining flush count is preserved and resumes after MEM_WAIT.
- MEM_WAIT state:
  - When mem_busy drops, the wait counter clears.
  - Next state is FLUSH if the flush count is nonzero, else RUN.
  - Same-cycle outputs follow the priority list.
  - A branch_taken held during the freeze is acted on in the first non-busy cycle.
- HALTED state: all enables 0, halted=1. Exit only by reset; all inputs are ignored.
- mem_busy pulses shorter than MEM_TIMEOUT never set the error flag, because the counter restarts after every non-busy cycle.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- When defined, three extra outputs are added:
  - load_stall_cnt[CNT_W-1:0]: cycles with a load-use bubble applied.
  - mem_stall_cnt[CNT_W-1:0]: mem_busy freeze cycles.
  - flush_cnt[CNT_W-1:0]: cycles with ifid_flush=1.
- Counter rules: saturate at all-ones, reset to 0, frozen in HALTED.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, then one load-use cycle (hz_nop_control=1, hz_pc_write=0) -> pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; the next normal cycle returns all enables to 1.
- branch_taken and hz_nop_control in the same cycle with FLUSH_CYCLES=2 -> ifid_flush=1 and pc_en=1 for 2 cycles, ctrl_state=1 for 1 cycle, no stall applied.
- mem_busy high for 5 cycles with branch_taken held -> all enables 0 for 5 cycles, ctrl_state=2; the cycle after the freeze gives ifid_flush=1 and mem_timeout_err stays 0.
- MEM_TIMEOUT=4, mem_busy held -> mem_timeout_err=1 after the 4th busy cycle, halted=1 the next cycle, outputs stay 0 after mem_busy drops.
- halt_req pulse, then rst_n asserted mid-HALTED -> halted=1 until reset; after release ctrl_state=0 and all enables 1.
- With STALL_PERF_CNT_EN and CNT_W=2: 5 load-use cycles -> load_stall_cnt=3, saturated.
